// File: rtl/jpeg_zz_quantizer_if.sv
// jpeg_zz_quantizer_if
// Bundles the coefficient stream, the reciprocal-table write port and the
// quantized output stream of the zigzag quantizer.
//   ena        : clock enable, freezes the whole pipeline when low
//   din        : zigzag-ordered signed coefficient (two's complement)
//   din_valid  : din is accepted on an enabled cycle
//   din_first  : marks zigzag index 0 of a block
//   qt_we      : reciprocal table write strobe (ignores ena)
//   qt_addr    : table write address (zigzag index)
//   qt_data    : reciprocal value, round(2^RW / Q)
//   dout       : quantized signed coefficient (two's complement)
//   dout_valid : dout is valid
//   dout_first : dout is zigzag index 0
//   dout_last  : dout is zigzag index 63
//   blk_err    : one-cycle pulse when a block start arrives mid-block
// master drives the stream and table port, slave is the quantizer.
interface jpeg_zz_quantizer_if #(
    parameter int DW = 12,
    parameter int RW = 16,
    parameter int OW = 11
);
    logic          ena;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_first;
    logic          qt_we;
    logic [5:0]    qt_addr;
    logic [RW-1:0] qt_data;
    logic [OW-1:0] dout;
    logic          dout_valid;
    logic          dout_first;
    logic          dout_last;
    logic          blk_err;

    modport master (
        output ena, din, din_valid, din_first, qt_we, qt_addr, qt_data,
        input  dout, dout_valid, dout_first, dout_last, blk_err
    );

    modport slave (
        input  ena, din, din_valid, din_first, qt_we, qt_addr, qt_data,
        output dout, dout_valid, dout_first, dout_last, blk_err
    );
endinterface

// File: rtl/jpeg_zz_quantizer.sv
// jpeg_zz_quantizer
// Quantizes zigzag-ordered DCT coefficients by multiplying each magnitude
// with a per-position reciprocal, rounding half away from zero, clamping
// symmetrically to +/-(2^(OW-1)-1) and restoring the sign. Three enabled
// cycles of latency, one coefficient per enabled cycle, no backpressure.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (table contents are kept)
//   bus : slave side of jpeg_zz_quantizer_if (stream in/out, table port)
module jpeg_zz_quantizer #(
    parameter int DW = 12,
    parameter int RW = 16,
    parameter int OW = 11
) (
    input logic                 clk,
    input logic                 rst,
    jpeg_zz_quantizer_if.slave  bus
);
    localparam int PW = DW + RW;
    localparam logic [OW-1:0] QMAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [PW:0]   HALF = {{(PW-RW+1){1'b0}}, 1'b1, {(RW-1){1'b0}}};

    logic [RW-1:0] qt_mem [64];

    logic [5:0]    idx_cnt;
    logic [5:0]    in_idx;
    logic [DW-1:0] in_mag;

    logic          s1_valid;
    logic          s1_sign;
    logic [DW-1:0] s1_mag;
    logic          s1_first;
    logic          s1_last;
    logic          s1_err;
    logic [RW-1:0] s1_recip;

    logic          s2_valid;
    logic          s2_sign;
    logic [PW-1:0] s2_prod;
    logic          s2_first;
    logic          s2_last;

    logic [DW:0]   q_mag;
    logic [OW-1:0] q_clamped;
    logic [OW-1:0] q_signed;

    logic [OW-1:0] dout_r;
    logic          dout_valid_r;
    logic          dout_first_r;
    logic          dout_last_r;

    // A block start forces index 0 regardless of where the counter is.
    assign in_idx = bus.din_first ? 6'd0 : idx_cnt;

    // Magnitude is kept unsigned so the most negative input (-2^(DW-1))
    // maps to 2^(DW-1) without overflowing.
    assign in_mag = bus.din[DW-1] ? (~bus.din + 1'b1) : bus.din;

    // Reciprocal table write port. It runs off qt_we alone so software can
    // load the table while the pipeline is stalled or held in reset.
    always_ff @(posedge clk) begin
        if (bus.qt_we) begin
            qt_mem[bus.qt_addr] <= bus.qt_data;
        end
    end

    // Stage 1: index tracking, sign/magnitude split and the synchronous
    // table read. The resync flag lives here and drives blk_err directly,
    // so the pulse appears one cycle after the offending block start.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_cnt  <= 6'd0;
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
            s1_recip <= '0;
        end else if (bus.ena) begin
            s1_valid <= bus.din_valid;
            s1_sign  <= bus.din[DW-1];
            s1_mag   <= in_mag;
            s1_first <= bus.din_valid & (in_idx == 6'd0);
            s1_last  <= bus.din_valid & (in_idx == 6'd63);
            s1_err   <= bus.din_valid & bus.din_first & (idx_cnt != 6'd0);
            s1_recip <= qt_mem[in_idx];
            if (bus.din_valid) begin
                idx_cnt <= in_idx + 6'd1;
            end
        end
    end

    // Stage 2: full-width unsigned product of magnitude and reciprocal.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_prod  <= '0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
        end else if (bus.ena) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_prod  <= {{RW{1'b0}}, s1_mag} * {{DW{1'b0}}, s1_recip};
            s2_first <= s1_first;
            s2_last  <= s1_last;
        end
    end

    // Rounding on the magnitude gives round-half-away-from-zero once the
    // sign is reapplied. The clamp is symmetric, and a zero result never
    // gets negated so there is no negative zero.
    always_comb begin
        q_mag     = (DW+1)'(({1'b0, s2_prod} + HALF) >> RW);
        q_clamped = (q_mag > {{(DW+1-OW){1'b0}}, QMAX}) ? QMAX : q_mag[OW-1:0];
        q_signed  = (s2_sign && (q_clamped != '0)) ? (~q_clamped + 1'b1) : q_clamped;
    end

    // Stage 3: registered outputs. dout only updates on a valid result so
    // it holds its last value across gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            dout_first_r <= 1'b0;
            dout_last_r  <= 1'b0;
        end else if (bus.ena) begin
            dout_valid_r <= s2_valid;
            dout_first_r <= s2_valid & s2_first;
            dout_last_r  <= s2_valid & s2_last;
            if (s2_valid) begin
                dout_r <= q_signed;
            end
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.dout_first = dout_first_r;
    assign bus.dout_last  = dout_last_r;
    assign bus.blk_err    = s1_err;

endmodule

// File: tb/tb_jpeg_zz_quantizer.sv
// tb_jpeg_zz_quantizer
// Directed stimulus for the zigzag quantizer with a scoreboard queue:
// expected outputs are pushed as inputs are driven and popped as the DUT
// emits valid results. Also tracks the expected blk_err pulse, reset
// values and output freezing while ena is low.
module tb_jpeg_zz_quantizer;
    localparam int DW = 12;
    localparam int RW = 16;
    localparam int OW = 11;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          f;
        logic          l;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    jpeg_zz_quantizer_if #(.DW(DW), .RW(RW), .OW(OW)) bus ();

    jpeg_zz_quantizer #(.DW(DW), .RW(RW), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic          q_rst   = 1'b0;
    logic          q_ena   = 1'b0;
    logic          exp_blk = 1'b0;
    logic          drv_err = 1'b0;
    logic [OW-1:0] p_dout;
    logic          p_valid;
    logic          p_first;
    logic          p_last;
    logic          p_err;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Capture what the DUT saw at each rising edge, and model blk_err:
    // it follows the resync marker of an accepted input, holds while stalled.
    always @(posedge clk) begin
        q_rst <= rst;
        q_ena <= bus.ena;
        if (rst) begin
            exp_blk <= 1'b0;
        end else if (bus.ena) begin
            exp_blk <= bus.din_valid & drv_err;
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q_rst) begin
            check_output("rst_dout_valid", bus.dout_valid, 0);
            check_output("rst_dout", bus.dout, 0);
            check_output("rst_dout_first", bus.dout_first, 0);
            check_output("rst_dout_last", bus.dout_last, 0);
            check_output("rst_blk_err", bus.blk_err, 0);
        end else if (!q_ena) begin
            check_output("hold_dout", bus.dout, p_dout);
            check_output("hold_valid", bus.dout_valid, p_valid);
            check_output("hold_first", bus.dout_first, p_first);
            check_output("hold_last", bus.dout_last, p_last);
            check_output("hold_blk_err", bus.blk_err, p_err);
        end else begin
            check_output("blk_err", bus.blk_err, exp_blk);
            if (bus.dout_valid) begin
                if (sb.size() == 0) begin
                    check_output("spurious_valid", bus.dout_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("dout", bus.dout, e.d);
                    check_output("dout_first", bus.dout_first, e.f);
                    check_output("dout_last", bus.dout_last, e.l);
                end
            end
        end
        p_dout  <= bus.dout;
        p_valid <= bus.dout_valid;
        p_first <= bus.dout_first;
        p_last  <= bus.dout_last;
        p_err   <= bus.blk_err;
    end

    // Drive one accepted coefficient and queue what it should turn into.
    task automatic apply_stimulus(input int d, input logic first, input int expd,
                                  input logic ef, input logic el, input logic err);
        exp_t e;
        @(negedge clk);
        rst           = 1'b0;
        bus.ena       = 1'b1;
        bus.din       = DW'(d);
        bus.din_valid = 1'b1;
        bus.din_first = first;
        bus.qt_we     = 1'b0;
        drv_err       = err;
        e.d = OW'(expd);
        e.f = ef;
        e.l = el;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.ena       = 1'b1;
            bus.din_valid = 1'b0;
            bus.din_first = 1'b0;
            bus.qt_we     = 1'b0;
            drv_err       = 1'b0;
        end
    endtask

    // ena low for n edges with garbage held on a valid input.
    task automatic stall(input int n);
        @(negedge clk);
        bus.ena       = 1'b0;
        bus.din       = 12'h7FF;
        bus.din_valid = 1'b1;
        bus.din_first = 1'b1;
        bus.qt_we     = 1'b0;
        drv_err       = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic load_table(input logic [RW-1:0] v);
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            bus.ena       = 1'b1;
            bus.din_valid = 1'b0;
            bus.din_first = 1'b0;
            drv_err       = 1'b0;
            bus.qt_we     = 1'b1;
            bus.qt_addr   = 6'(a);
            bus.qt_data   = v;
        end
        @(negedge clk);
        bus.qt_we = 1'b0;
    endtask

    // Reset with a simultaneous valid input that must be dropped; in-flight
    // expectations are discarded once the reset edge has passed.
    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.ena       = 1'b1;
        bus.din       = 12'h123;
        bus.din_valid = 1'b1;
        bus.din_first = 1'b0;
        drv_err       = 1'b0;
        @(negedge clk);
        rst           = 1'b0;
        bus.din_valid = 1'b0;
        sb.delete();
    endtask

    initial begin
        int rnd_in [5];
        int rnd_out[5];
        int clp_in [3];
        int clp_out[3];
        rnd_in  = '{3, -3, -1, 1, 0};
        rnd_out = '{2, -2, -1, 1, 0};
        clp_in  = '{-2048, 2047, -1};
        clp_out = '{-1023, 1023, -1};

        rst           = 1'b1;
        bus.ena       = 1'b1;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.din_first = 1'b0;
        bus.qt_we     = 1'b0;
        bus.qt_addr   = '0;
        bus.qt_data   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full block at Q=16: dout equals k.
        load_table(16'h1000);
        for (int k = 0; k < 64; k++)
            apply_stimulus(16 * k, k == 0, k, k == 0, k == 63, 1'b0);
        idle(4);

        // Rounding at Q=2, indices 0..4.
        load_table(16'h8000);
        for (int i = 0; i < 5; i++)
            apply_stimulus(rnd_in[i], i == 0, rnd_out[i], i == 0, 1'b0, 1'b0);

        // Clamp with the largest reciprocal, indices 5..7, then finish the block.
        load_table(16'hFFFF);
        for (int i = 0; i < 3; i++)
            apply_stimulus(clp_in[i], 1'b0, clp_out[i], 1'b0, 1'b0, 1'b0);
        for (int i = 8; i < 64; i++)
            apply_stimulus(0, 1'b0, 0, 1'b0, i == 63, 1'b0);
        idle(4);

        // Resync on the 21st coefficient, then a full block from there.
        load_table(16'h1000);
        for (int j = 0; j < 20; j++)
            apply_stimulus(16 * j, j == 0, j, j == 0, 1'b0, 1'b0);
        for (int j = 0; j < 64; j++)
            apply_stimulus(-16 * j, j == 0, -j, j == 0, j == 63, j == 0);
        idle(3);

        // Stall at index 30; rewrite entry 5 on the cycle it is read.
        for (int k = 0; k < 64; k++) begin
            if (k == 30) stall(5);
            apply_stimulus(16 * k, k == 0, k, k == 0, k == 63, 1'b0);
            if (k == 5) begin
                bus.qt_we   = 1'b1;
                bus.qt_addr = 6'd5;
                bus.qt_data = 16'h0800;
            end
        end

        // Next block sees Q=32 at index 5: 80/32 = 2.5 rounds to 3.
        for (int k = 0; k < 64; k++)
            apply_stimulus(16 * k, k == 0, (k == 5) ? 3 : k, k == 0, k == 63, 1'b0);

        // Reset mid-block at index 30; next input is index 0 without din_first.
        for (int k = 0; k <= 30; k++)
            apply_stimulus(16 * k, k == 0, (k == 5) ? 3 : k, k == 0, 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 64; k++)
            apply_stimulus(16 * k, 1'b0, (k == 5) ? 3 : k, k == 0, k == 63, 1'b0);

        idle(8);
        check_output("drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
